axis_multibank_packet_buffer: RTL and testbench

//  N-bank generalisation of the AXI-Stream ping-pong buffer: NUM_BANKS segment banks filled and drained round-robin.

---
 rtl/axis_multibank_packet_buffer_if.sv | 15 +
 rtl/axis_multibank_packet_buffer.sv | 133 +++++++++++++
 tb/tb_axis_multibank_packet_buffer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_multibank_packet_buffer_if.sv
// AXI-Stream bundle shared by the slave (input) and master (output) sides of the
// multibank packet buffer.
interface axis_multibank_packet_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_multibank_packet_buffer.sv
// Round-robin N-bank store-and-forward AXI-Stream buffer. Segments close on tlast or
// when a bank fills, so long packets span several banks with framing preserved.
module axis_multibank_packet_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_DEPTH  = 2 ** ADDR_WIDTH,
  parameter int NUM_BANKS  = 4,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_multibank_packet_buffer_if.slave  s_axis,
  axis_multibank_packet_buffer_if.master m_axis,
  output logic [NUM_BANKS-1:0]  bank_full,
  output logic [BANK_W:0]       banks_pending
);
  localparam int WORD_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(MAX_DEPTH - 1);
  localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [WORD_W-1:0] mem [NUM_BANKS][MAX_DEPTH];

  logic [BANK_W-1:0]     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NUM_BANKS-1:0]  bank_full_q, bank_full_d;
  logic [ADDR_WIDTH:0]   len_q [NUM_BANKS];
  logic [ADDR_WIDTH:0]   len_d [NUM_BANKS];
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tvalid_q, m_tvalid_d;

  logic              wr_fire, wr_close, load, rd_last;
  logic [WORD_W-1:0] rd_word;
  logic [BANK_W:0]   pending_cnt;

  always_comb begin
    wr_fire  = s_axis.tvalid && !bank_full_q[wr_bank_q];
    wr_close = wr_fire && (s_axis.tlast || wr_ptr_q == LAST_IDX);
    rd_word  = mem[rd_bank_q][rd_ptr_q];
    rd_last  = ({1'b0, rd_ptr_q} + (ADDR_WIDTH + 1)'(1)) == len_q[rd_bank_q];
    load     = bank_full_q[rd_bank_q] && (!m_tvalid_q || m_axis.tready);

    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    bank_full_d = bank_full_q;
    len_d       = len_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    m_tvalid_d  = m_tvalid_q;

    if (wr_fire) begin
      if (wr_close) begin
        len_d[wr_bank_q]       = {1'b0, wr_ptr_q} + (ADDR_WIDTH + 1)'(1);
        bank_full_d[wr_bank_q] = 1'b1;
        wr_ptr_d               = '0;
        wr_bank_d              = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BANK_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
    end

    // A writer only ever closes a non-full bank and the reader only releases a full
    // one, so the set above and the clear below never target the same bank.
    if (load) begin
      {m_tlast_d, m_tkeep_d, m_tdata_d} = rd_word;
      m_tvalid_d = 1'b1;
      if (rd_last) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_ptr_d               = '0;
        rd_bank_d              = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + BANK_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      end
    end else if (m_axis.tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      pending_cnt = pending_cnt + (BANK_W + 1)'(bank_full_q[i]);
    end
  end

  // Bank RAM has no reset; stale contents are unreachable because len/bank_full clear.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank_q][wr_ptr_q] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bank_full_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        len_q[i] <= '0;
      end
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bank_full_q <= bank_full_d;
      len_q       <= len_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
    end
  end

  assign s_axis.tready = !bank_full_q[wr_bank_q];
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tkeep  = m_tkeep_q;
  assign m_axis.tlast  = m_tlast_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign bank_full     = bank_full_q;
  assign banks_pending = pending_cnt;
endmodule

// File: tb/tb_axis_multibank_packet_buffer.sv
// Self-checking bench for axis_multibank_packet_buffer: a hand-written vector table,
// directed corner sequences and a randomized run against a count-based reference model.
module tb_axis_multibank_packet_buffer;
  localparam int NB   = 4;
  localparam int MAXD = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NB-1:0]  bank_full;
  logic [2:0]     banks_pending;

  axis_multibank_packet_buffer_if #(.DATA_WIDTH(64)) s_if ();
  axis_multibank_packet_buffer_if #(.DATA_WIDTH(64)) m_if ();

  axis_multibank_packet_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .bank_full     (bank_full),
    .banks_pending (banks_pending)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted beat goes into exp_q; the model only tracks
  // beat counts (written, loaded into the output register) and the cumulative
  // beat index at which each still-occupied segment ends.
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    seg_ends[$];
  int    total_written, closed_total, loaded, wr_cnt;
  bit    mdl_tvalid, last_in_hs;

  bit          prev_stall;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;

  int vectors, miscompares, out_beats, out_lasts, cycles;

  typedef struct {
    logic        sv;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    logic        mr;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [2:0]  ep;
  } vec_t;

  vec_t tbl [7];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    seg_ends.delete();
    total_written = 0;
    closed_total  = 0;
    loaded        = 0;
    wr_cnt        = 0;
    mdl_tvalid    = 1'b0;
    prev_stall    = 1'b0;
  endtask

  // Compare the DUT against the model, then advance both across one rising edge.
  task automatic cycle();
    beat_t b;
    bit    in_hs;
    checkOutput("m_tvalid", 64'(m_if.tvalid), 64'(mdl_tvalid));
    checkOutput("banks_pending", 64'(banks_pending), 64'(seg_ends.size()));
    checkOutput("s_tready", 64'(s_if.tready), 64'(seg_ends.size() < NB));
    if (prev_stall) begin
      checkOutput("stall_tdata", m_if.tdata, prev_data);
      checkOutput("stall_tkeep", 64'(m_if.tkeep), 64'(prev_keep));
      checkOutput("stall_tlast", 64'(m_if.tlast), 64'(prev_last));
    end
    if (mdl_tvalid && m_if.tready) begin
      checkOutput("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        checkOutput("out_tdata", m_if.tdata, b.d);
        checkOutput("out_tkeep", 64'(m_if.tkeep), 64'(b.k));
        checkOutput("out_tlast", 64'(m_if.tlast), 64'(b.l));
        out_beats++;
        if (b.l) out_lasts++;
      end
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_data  = m_if.tdata;
    prev_keep  = m_if.tkeep;
    prev_last  = m_if.tlast;

    in_hs = s_if.tvalid && (seg_ends.size() < NB);
    if ((!mdl_tvalid || m_if.tready) && closed_total > loaded) begin
      loaded++;
      mdl_tvalid = 1'b1;
      while (seg_ends.size() != 0 && seg_ends[0] <= loaded) void'(seg_ends.pop_front());
    end else if (m_if.tready) begin
      mdl_tvalid = 1'b0;
    end
    if (in_hs) begin
      b.d = s_if.tdata;
      b.k = s_if.tkeep;
      b.l = s_if.tlast;
      exp_q.push_back(b);
      total_written++;
      wr_cnt++;
      if (s_if.tlast || wr_cnt == MAXD) begin
        seg_ends.push_back(total_written);
        closed_total = total_written;
        wr_cnt = 0;
      end
    end
    last_in_hs = in_hs;
    @(posedge clk);
    @(negedge clk);
    cycles++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    checkOutput("rst_m_tdata", m_if.tdata, 64'(0));
    checkOutput("rst_m_tkeep", 64'(m_if.tkeep), 64'(0));
    checkOutput("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    checkOutput("rst_s_tready", 64'(s_if.tready), 64'(1));
    checkOutput("rst_bank_full", 64'(bank_full), 64'(0));
    checkOutput("rst_banks_pending", 64'(banks_pending), 64'(0));
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Hold one beat until accepted; ready_mode 0 = stalled, 1 = ready, 2 = random.
  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input int ready_mode, input bit rand_valid);
    int n = 0;
    bit done = 0;
    s_if.tdata = d;
    s_if.tkeep = k;
    s_if.tlast = l;
    while (!done && n < 2000) begin
      s_if.tvalid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_if.tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
      cycle();
      done = last_in_hs;
      n++;
    end
    s_if.tvalid = 1'b0;
    checkOutput("beat_accept_in_budget", 64'(done), 64'(1));
  endtask

  task automatic drain(input int ready_mode, input int budget);
    int n = 0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    while ((exp_q.size() != 0 || mdl_tvalid) && n < budget) begin
      m_if.tready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    checkOutput("drain_complete", 64'(n < budget), 64'(1));
  endtask

  initial begin
    int hs, stalls, len;
    vectors = 0; miscompares = 0; out_beats = 0; out_lasts = 0; cycles = 0;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;

    // 3-beat packet timing, values worked out by hand from the buffer's rules.
    tbl[0] = '{1'b1, 64'h11, 8'hFF, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 3'd0};
    tbl[1] = '{1'b1, 64'h22, 8'hFF, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 3'd0};
    tbl[2] = '{1'b1, 64'h33, 8'h0F, 1'b1, 1'b1, 1'b0, 64'h0,  1'b0, 3'd1};
    tbl[3] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 1'b1, 64'h11, 1'b0, 3'd1};
    tbl[4] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 1'b1, 64'h22, 1'b0, 3'd1};
    tbl[5] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 1'b1, 64'h33, 1'b1, 3'd0};
    tbl[6] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 3'd0};

    @(negedge clk);
    doReset();

    for (int i = 0; i < 7; i++) begin
      s_if.tvalid = tbl[i].sv;
      s_if.tdata  = tbl[i].sd;
      s_if.tkeep  = tbl[i].sk;
      s_if.tlast  = tbl[i].sl;
      m_if.tready = tbl[i].mr;
      cycle();
      checkOutput($sformatf("tbl%0d_tvalid", i), 64'(m_if.tvalid), 64'(tbl[i].ev));
      checkOutput($sformatf("tbl%0d_pending", i), 64'(banks_pending), 64'(tbl[i].ep));
      if (tbl[i].ev) begin
        checkOutput($sformatf("tbl%0d_tdata", i), m_if.tdata, tbl[i].ed);
        checkOutput($sformatf("tbl%0d_tlast", i), 64'(m_if.tlast), 64'(tbl[i].el));
      end
    end
    s_if.tvalid = 1'b0;

    $display("[TB] 150-beat packet across three banks");
    doReset();
    out_beats = 0; out_lasts = 0;
    for (int i = 0; i < 150; i++) applyStimulus(64'(i + 1000), 8'hFF, i == 149, 1, 1'b0);
    drain(1, 500);
    checkOutput("long_pkt_beats", 64'(out_beats), 64'(150));
    checkOutput("long_pkt_tlasts", 64'(out_lasts), 64'(1));

    $display("[TB] stalled output, one-beat packets fill every bank");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(64'(i + 1), 8'hFF, 1'b1, 0, 1'b0);
    checkOutput("full_pending", 64'(banks_pending), 64'(4));
    checkOutput("full_s_tready", 64'(s_if.tready), 64'(0));
    checkOutput("full_head_tdata", m_if.tdata, 64'(1));
    s_if.tdata = 64'd6; s_if.tkeep = 8'hFF; s_if.tlast = 1'b1; s_if.tvalid = 1'b1;
    m_if.tready = 1'b0;
    cycle();
    cycle();
    checkOutput("blocked_pending", 64'(banks_pending), 64'(4));
    m_if.tready = 1'b1;
    cycle();
    checkOutput("release_pending", 64'(banks_pending), 64'(3));
    checkOutput("release_s_tready", 64'(s_if.tready), 64'(1));
    checkOutput("release_tdata", m_if.tdata, 64'(2));
    m_if.tready = 1'b0;
    cycle();
    checkOutput("sixth_accepted", 64'(last_in_hs), 64'(1));
    checkOutput("sixth_pending", 64'(banks_pending), 64'(4));
    s_if.tvalid = 1'b0;
    drain(1, 200);

    $display("[TB] back-to-back single-beat packets");
    doReset();
    hs = 0; stalls = 0;
    for (int i = 0; i < 40; i++) begin
      s_if.tvalid = 1'b1; s_if.tdata = 64'(32'hA000 + i); s_if.tkeep = 8'h3C; s_if.tlast = 1'b1;
      m_if.tready = 1'b1;
      if (i >= 10 && i < 30 && m_if.tvalid) hs++;
      cycle();
      if (!last_in_hs) stalls++;
    end
    checkOutput("b2b_output_rate", 64'(hs), 64'(20));
    checkOutput("b2b_input_stalls", 64'(stalls), 64'(0));
    drain(1, 100);

    $display("[TB] reset with two banks full and a packet in flight");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(64'(16'hA0 + i), 8'hFF, i == 2, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(64'(16'hB0 + i), 8'hFF, i == 2, 0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(64'(16'hC0 + i), 8'hFF, 1'b0, 0, 1'b0);
    checkOutput("pre_rst_bank_full", 64'(bank_full), 64'(4'b0011));
    checkOutput("pre_rst_pending", 64'(banks_pending), 64'(2));
    s_if.tvalid = 1'b1;
    doReset();
    applyStimulus(64'hD0, 8'h01, 1'b0, 0, 1'b0);
    applyStimulus(64'hD1, 8'h03, 1'b1, 0, 1'b0);
    checkOutput("post_rst_bank0", 64'(bank_full), 64'(4'b0001));
    drain(1, 100);

    $display("[TB] randomized packets with random backpressure");
    doReset();
    for (int p = 0; p < 1000 && cycles < 80000; p++) begin
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(60, 140)) : int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        applyStimulus({$urandom, $urandom}, 8'($urandom_range(1, 255)), i == len - 1, 2, 1'b1);
      end
    end
    checkOutput("random_within_cycle_budget", 64'(cycles < 80000), 64'(1));
    drain(2, 5000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
